sti_load_scheduler: RTL and testbench
=====================================

Name: sti_load_scheduler

Overview:
Command scheduler in front of the STI/DAC serializer. It arbitrates round-robin between two command requesters and buffers accepted commands in a small FIFO. It sequences each command into the STI load protocol (one-cycle load, stable pi_* fields) and tracks completion through so_valid. It enforces a byte budget for the frame and ends the frame with pi_end, then waits for oem_finish.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
BUDGET_BYTES, 256, frame byte budget (1..256)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_cmd  in  21  {low[20], msb[19], fill[18], length[17:16], data[15:0]}
req0_ready  out  1  requester 0 accept (combinational)
req1_valid  in  1  requester 1 command valid
req1_cmd  in  21  same format as req0_cmd
req1_ready  out  1  requester 1 accept (combinational)
flush_req  in  1  single-cycle pulse: end frame after queued commands drain
so_valid  in  1  STI serial-valid, monitored for completion
oem_finish  in  1  DAC frame-complete indication
load  out  1  STI load pulse
pi_data  out  16  STI parallel data
pi_length  out  2  STI length code (0..3 = 8/16/24/32 bits)
pi_fill, pi_msb, pi_low  out  1 each  STI mode bits
pi_end  out  1  STI end-of-frame
busy  out  1  state != IDLE or FIFO non-empty
done  out  1  frame complete, sticky until reset
bytes_sent  out  9  bytes completed on the STI
err_overflow  out  1  sticky: a command was dropped for exceeding the budget
err_length  out  1  sticky: so_valid burst length did not match the command

Behaviour:
- Reset: all registered outputs 0; FIFO empty; rr pointer = 0; committed = 0; flush_pending = 0. Both ready outputs are forced to 0 while reset is high.
- Command byte count nb = length + 1.
- Accept condition (can_accept): FIFO count < FIFO_DEPTH, and no flush_pending, and state not END/DONE.
- Grant rules:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by rr is granted.
  - reqN_ready = can_accept & grant==N; at most one ready high per cycle.
  - On a handshake, rr points to the other requester.
- Budget check on accept:
  - committed + nb <= BUDGET_BYTES: push command, committed += nb.
  - Otherwise: handshake still completes, command is discarded, err_overflow set.
- flush_req: sets flush_pending. A handshake in the same cycle is still accepted.
- FSM:
  - IDLE: FIFO non-empty -> LOAD. Else if flush_pending or committed == BUDGET_BYTES -> END.
  - LOAD: load=1 for exactly this cycle. Register pi_* from the FIFO head, pop -> WAIT_START. pi_* hold their values until the next LOAD.
  - WAIT_START: so_valid==1 -> WAIT_END; bit counter = 1.
  - WAIT_END: while so_valid==1, bit counter++. On so_valid==0:
    - bytes_sent += nb.
    - err_length set if bit counter != 8*nb.
    - -> GAP.
  - GAP: single idle cycle so the STI returns to its idle state -> IDLE.
  - END: pi_end=1, held; load never asserted. oem_finish==1 -> DONE.
  - DONE: pi_end=1, done=1; all ready=0 until reset.
- Push and pop in the same cycle are legal. FIFO wraps modulo FIFO_DEPTH.
- committed and bytes_sent saturate at BUDGET_BYTES; they never wrap.
- Reset asserted mid-operation (any state) returns everything to reset values immediately. Queued commands are lost.

Test Plan:
1. req0_cmd = {0,1,0,2'd0,16'hA5C3}; STI model drives so_valid for 8 cycles. Required: one load pulse; pi_data=16'hA5C3, pi_length=0, pi_msb=1 stable until the next LOAD; bytes_sent=1; busy=0 two cycles after so_valid falls.
2. req0 and req1 both continuously valid, 4 commands each, FIFO never full. Required: accept order 0,1,0,1,0,1,0,1; never both ready=1; LOAD order matches accept order.
3. STI model holds so_valid low indefinitely after the first load; push 7 commands. Required: 5 accepted (1 in flight plus 4 queued); 6th requester sees ready=0; counts resume once so_valid completes.
4. BUDGET_BYTES=16: four length=3 commands, then one length=0 command. Required: the fifth handshake completes, err_overflow=1, the fifth is never loaded; bytes_sent=16; FSM enters END automatically with pi_end=1.
5. Two length=1 commands, then a flush_req pulse; oem_finish asserted 20 cycles after pi_end. Required: pi_end rises only after the second GAP; done=1 one cycle after oem_finish; later req valids see ready=0.
6. length=0 command with a 12-cycle so_valid burst -> err_length=1, bytes_sent+=1. Then reset asserted during WAIT_END -> all outputs 0 in the same cycle, FIFO empty.

Source files
------------

// File: rtl/sti_load_scheduler_if.sv
// -----------------------------------------------------------------------------
// sti_load_scheduler_if
// Command request bus between two requesters and the STI load scheduler.
//   reqN_valid : requester N offers a command
//   reqN_cmd   : {low[20], msb[19], fill[18], length[17:16], data[15:0]}
//   reqN_ready : scheduler accepts the offered command this cycle
// master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface sti_load_scheduler_if;
    logic        req0_valid;
    logic [20:0] req0_cmd;
    logic        req0_ready;
    logic        req1_valid;
    logic [20:0] req1_cmd;
    logic        req1_ready;

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/sti_load_scheduler.sv
// -----------------------------------------------------------------------------
// sti_load_scheduler
// Round-robin arbiter for two command requesters feeding a small command FIFO,
// sequencer that plays each command into the STI load protocol, byte budget
// enforcement and end-of-frame handling (pi_end, then wait for oem_finish).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_if (slave)      : two valid/ready command requesters
//   flush_req_i         : pulse, end the frame once queued commands drain
//   so_valid_i          : STI serial valid, used to track completion
//   oem_finish_i        : DAC frame complete
//   load_o, pi_*_o      : STI load pulse and parallel command fields
//   pi_end_o            : STI end-of-frame
//   busy_o, done_o      : activity / frame complete (sticky)
//   bytes_sent_o        : bytes completed on the STI (saturating)
//   err_overflow_o      : sticky, a command was dropped for the budget
//   err_length_o        : sticky, so_valid burst length mismatched
// -----------------------------------------------------------------------------
module sti_load_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUDGET_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    sti_load_scheduler_if.slave  req_if,
    input  logic                 flush_req_i,
    input  logic                 so_valid_i,
    input  logic                 oem_finish_i,
    output logic                 load_o,
    output logic [15:0]          pi_data_o,
    output logic [1:0]           pi_length_o,
    output logic                 pi_fill_o,
    output logic                 pi_msb_o,
    output logic                 pi_low_o,
    output logic                 pi_end_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [8:0]           bytes_sent_o,
    output logic                 err_overflow_o,
    output logic                 err_length_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       BUDGET_C     = 10'(BUDGET_BYTES);
    localparam logic [8:0]       BUDGET_SAT_C = 9'(BUDGET_BYTES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_END   = 3'd3,
        S_GAP        = 3'd4,
        S_END        = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t             state_q;
    logic [20:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [8:0]         committed_q;
    logic               rr_q;
    logic               flush_pending_q;
    logic               load_q;
    logic [20:0]        pi_q;
    logic               pi_end_q;
    logic               done_q;
    logic               busy_q;
    logic [8:0]         bytes_sent_q;
    logic               err_overflow_q;
    logic               err_length_q;
    logic [5:0]         bit_cnt_q;
    logic [2:0]         cur_nb_q;

    logic               can_accept_s;
    logic               grant_s;
    logic               hs_s;
    logic               fits_s;
    logic               push_s;
    logic               pop_s;
    logic [20:0]        hs_cmd_s;
    logic [2:0]         hs_nb_s;
    logic [9:0]         commit_sum_s;
    logic [9:0]         sent_sum_s;

    // Arbitration, budget check and FIFO occupancy for the current cycle.
    always_comb begin
        can_accept_s = (count_q < DEPTH_C) && !flush_pending_q &&
                       (state_q != S_END) && (state_q != S_DONE);
        // With no contention the lone requester wins; otherwise rr decides.
        if (req_if.req0_valid && !req_if.req1_valid) begin
            grant_s = 1'b0;
        end else if (req_if.req1_valid && !req_if.req0_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = rr_q;
        end
        hs_cmd_s     = grant_s ? req_if.req1_cmd : req_if.req0_cmd;
        hs_s         = !reset && can_accept_s &&
                       (grant_s ? req_if.req1_valid : req_if.req0_valid);
        hs_nb_s      = {1'b0, hs_cmd_s[17:16]} + 3'd1;
        commit_sum_s = {1'b0, committed_q} + {7'd0, hs_nb_s};
        fits_s       = (commit_sum_s <= BUDGET_C);
        push_s       = hs_s && fits_s;
        pop_s        = (state_q == S_IDLE) && (count_q != {CNT_W{1'b0}});
        sent_sum_s   = {1'b0, bytes_sent_q} + {7'd0, cur_nb_q};
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    assign req_if.req0_ready = !reset && can_accept_s && !grant_s;
    assign req_if.req1_ready = !reset && can_accept_s &&  grant_s;

    // Command FIFO, committed byte total, round-robin pointer and flush latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 21'd0;
            end
            wr_ptr_q        <= {PTR_W{1'b0}};
            rd_ptr_q        <= {PTR_W{1'b0}};
            count_q         <= {CNT_W{1'b0}};
            committed_q     <= 9'd0;
            rr_q            <= 1'b0;
            flush_pending_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= hs_cmd_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                committed_q     <= commit_sum_s[8:0];
            end
            // Over-budget commands still complete the handshake but are dropped.
            if (hs_s && !fits_s) begin
                err_overflow_q <= 1'b1;
            end
            if (hs_s) begin
                rr_q <= ~grant_s;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (flush_req_i) begin
                flush_pending_q <= 1'b1;
            end
        end
    end

    // Load sequencer FSM with all STI-facing and status outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_q       <= 1'b0;
            pi_q         <= 21'd0;
            pi_end_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            bytes_sent_q <= 9'd0;
            err_length_q <= 1'b0;
            bit_cnt_q    <= 6'd0;
            cur_nb_q     <= 3'd0;
        end else begin
            busy_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    // pi_* are captured together with the load pulse so the
                    // STI sees stable fields in the load cycle itself.
                    if (count_q != {CNT_W{1'b0}}) begin
                        state_q  <= S_LOAD;
                        load_q   <= 1'b1;
                        pi_q     <= mem_q[rd_ptr_q];
                        cur_nb_q <= {1'b0, mem_q[rd_ptr_q][17:16]} + 3'd1;
                    end else if (flush_pending_q || (committed_q == BUDGET_SAT_C)) begin
                        state_q  <= S_END;
                        pi_end_q <= 1'b1;
                    end else begin
                        busy_q <= (count_d != {CNT_W{1'b0}});
                    end
                end
                S_LOAD: begin
                    load_q  <= 1'b0;
                    state_q <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (so_valid_i) begin
                        bit_cnt_q <= 6'd1;
                        state_q   <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (so_valid_i) begin
                        // Saturate: any count past 32 is already a mismatch.
                        if (bit_cnt_q != 6'h3F) begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end else begin
                        bytes_sent_q <= (sent_sum_s > BUDGET_C) ? BUDGET_SAT_C : sent_sum_s[8:0];
                        if (bit_cnt_q != {cur_nb_q, 3'b000}) begin
                            err_length_q <= 1'b1;
                        end
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                    busy_q  <= (count_d != {CNT_W{1'b0}});
                end
                S_END: begin
                    if (oem_finish_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                    load_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load_o         = load_q;
    assign pi_data_o      = pi_q[15:0];
    assign pi_length_o    = pi_q[17:16];
    assign pi_fill_o      = pi_q[18];
    assign pi_msb_o       = pi_q[19];
    assign pi_low_o       = pi_q[20];
    assign pi_end_o       = pi_end_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign bytes_sent_o   = bytes_sent_q;
    assign err_overflow_o = err_overflow_q;
    assign err_length_o   = err_length_q;

endmodule

// File: tb/tb_sti_load_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sti_load_scheduler
// Randomized bench for sti_load_scheduler. A behavioural model (command queue,
// byte totals, current activity of the scheduler) predicts every output each
// cycle; the bench also plays the STI, answering each load with a so_valid
// burst after a random delay (occasionally of the wrong length).
// -----------------------------------------------------------------------------
module tb_sti_load_scheduler;
    localparam int DEPTH     = 4;
    localparam int BUDGET    = 16;
    localparam int EPISODES  = 12;
    localparam int EP_CYCLES = 250;

    logic        clk;
    logic        reset;
    logic        flush_req;
    logic        so_valid;
    logic        oem_finish;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        busy;
    logic        done;
    logic [8:0]  bytes_sent;
    logic        err_overflow;
    logic        err_length;

    sti_load_scheduler_if req_if ();

    sti_load_scheduler #(.FIFO_DEPTH(DEPTH), .BUDGET_BYTES(BUDGET)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_if         (req_if),
        .flush_req_i    (flush_req),
        .so_valid_i     (so_valid),
        .oem_finish_i   (oem_finish),
        .load_o         (load),
        .pi_data_o      (pi_data),
        .pi_length_o    (pi_length),
        .pi_fill_o      (pi_fill),
        .pi_msb_o       (pi_msb),
        .pi_low_o       (pi_low),
        .pi_end_o       (pi_end),
        .busy_o         (busy),
        .done_o         (done),
        .bytes_sent_o   (bytes_sent),
        .err_overflow_o (err_overflow),
        .err_length_o   (err_length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the scheduler is doing, from the outside point of view.
    typedef enum int {M_IDLE, M_LOADING, M_AWAIT, M_BURST, M_GAP, M_ENDED, M_DONE} mphase_t;

    logic [20:0] m_q [$];
    mphase_t     m_phase;
    logic [20:0] m_pi;
    int          m_committed;
    int          m_bytes;
    int          m_bits;
    int          m_cur_nb;
    bit          m_rr;
    bit          m_flush;
    bit          m_eovf;
    bit          m_elen;

    int errors;
    int checks;
    int sti_wait;
    int sti_high;
    int p_valid;
    int p_flush;
    int p_bad;
    int stall_max;
    bit exp_r0;
    bit exp_r1;
    bit exp_grant;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_phase     = M_IDLE;
        m_pi        = 21'd0;
        m_committed = 0;
        m_bytes     = 0;
        m_bits      = 0;
        m_cur_nb    = 0;
        m_rr        = 1'b0;
        m_flush     = 1'b0;
        m_eovf      = 1'b0;
        m_elen      = 1'b0;
        sti_wait    = 0;
        sti_high    = 0;
    endfunction

    task automatic zero_inputs();
        req_if.req0_valid = 1'b0;
        req_if.req0_cmd   = 21'd0;
        req_if.req1_valid = 1'b0;
        req_if.req1_cmd   = 21'd0;
        flush_req         = 1'b0;
        so_valid          = 1'b0;
        oem_finish        = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_busy;
        exp_busy = (m_phase != M_IDLE) || (m_q.size() != 0);
        check_val("load",       32'(load),         32'(m_phase == M_LOADING));
        check_val("pi_data",    32'(pi_data),      32'(m_pi[15:0]));
        check_val("pi_length",  32'(pi_length),    32'(m_pi[17:16]));
        check_val("pi_fill",    32'(pi_fill),      32'(m_pi[18]));
        check_val("pi_msb",     32'(pi_msb),       32'(m_pi[19]));
        check_val("pi_low",     32'(pi_low),       32'(m_pi[20]));
        check_val("pi_end",     32'(pi_end),       32'((m_phase == M_ENDED) || (m_phase == M_DONE)));
        check_val("done",       32'(done),         32'(m_phase == M_DONE));
        check_val("busy",       32'(busy),         32'(exp_busy));
        check_val("bytes_sent", 32'(bytes_sent),   32'(m_bytes));
        check_val("err_ovf",    32'(err_overflow), 32'(m_eovf));
        check_val("err_len",    32'(err_length),   32'(m_elen));
    endtask

    task automatic drive_inputs();
        req_if.req0_valid = ($urandom_range(99) < p_valid);
        req_if.req0_cmd   = 21'($urandom());
        req_if.req1_valid = ($urandom_range(99) < p_valid);
        req_if.req1_cmd   = 21'($urandom());
        flush_req         = ($urandom_range(999) < p_flush);
        oem_finish        = ($urandom_range(3) == 0);
        // STI: each load is answered by one burst after a random delay.
        if (m_phase == M_LOADING) begin
            sti_wait = $urandom_range(stall_max);
            if ($urandom_range(99) < p_bad) begin
                sti_high = $urandom_range(40, 1);
            end else begin
                sti_high = 8 * m_cur_nb;
            end
            so_valid = 1'b0;
        end else if (sti_wait > 0) begin
            so_valid = 1'b0;
            sti_wait--;
        end else if (sti_high > 0) begin
            so_valid = 1'b1;
            sti_high--;
        end else begin
            so_valid = 1'b0;
        end
    endtask

    task automatic predict_ready();
        bit can;
        can = (m_q.size() < DEPTH) && !m_flush && (m_phase != M_ENDED) && (m_phase != M_DONE);
        if (req_if.req0_valid && !req_if.req1_valid) exp_grant = 1'b0;
        else if (req_if.req1_valid && !req_if.req0_valid) exp_grant = 1'b1;
        else exp_grant = m_rr;
        exp_r0 = can && !exp_grant;
        exp_r1 = can && exp_grant;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int          nb;
        bit          hs;
        logic [20:0] cmd;
        case (m_phase)
            M_IDLE: begin
                if (m_q.size() > 0) begin
                    m_pi     = m_q.pop_front();
                    m_cur_nb = int'(m_pi[17:16]) + 1;
                    m_phase  = M_LOADING;
                end else if (m_flush || (m_committed == BUDGET)) begin
                    m_phase = M_ENDED;
                end
            end
            M_LOADING: m_phase = M_AWAIT;
            M_AWAIT: begin
                if (so_valid) begin
                    m_phase = M_BURST;
                    m_bits  = 1;
                end
            end
            M_BURST: begin
                if (so_valid) begin
                    m_bits++;
                end else begin
                    m_bytes = (m_bytes + m_cur_nb > BUDGET) ? BUDGET : m_bytes + m_cur_nb;
                    if (m_bits != 8 * m_cur_nb) m_elen = 1'b1;
                    m_phase = M_GAP;
                end
            end
            M_GAP:   m_phase = M_IDLE;
            M_ENDED: if (oem_finish) m_phase = M_DONE;
            default: ;
        endcase
        hs  = exp_grant ? (req_if.req1_valid && exp_r1) : (req_if.req0_valid && exp_r0);
        cmd = exp_grant ? req_if.req1_cmd : req_if.req0_cmd;
        if (hs) begin
            nb = int'(cmd[17:16]) + 1;
            if (m_committed + nb <= BUDGET) begin
                m_q.push_back(cmd);
                m_committed += nb;
            end else begin
                m_eovf = 1'b1;
            end
            m_rr = !exp_grant;
        end
        if (flush_req) m_flush = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycle();
        check_outputs();
        drive_inputs();
        #1;
        predict_ready();
        check_val("ready0", 32'(req_if.req0_ready), 32'(exp_r0));
        check_val("ready1", 32'(req_if.req1_ready), 32'(exp_r1));
        model_step();
        @(negedge clk);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        p_valid   = 50;
        p_flush   = 0;
        p_bad     = 0;
        stall_max = 0;
        zero_inputs();
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_if.req0_valid = 1'b1;
        req_if.req1_valid = 1'b1;
        #1;
        check_outputs();
        check_val("reset_ready0", 32'(req_if.req0_ready), 32'd0);
        check_val("reset_ready1", 32'(req_if.req1_ready), 32'd0);
        @(negedge clk);
        zero_inputs();
        reset = 1'b0;

        for (int ep = 0; ep < EPISODES; ep++) begin
            p_valid   = (ep % 3 == 0) ? 90 : ((ep % 3 == 1) ? 40 : 15);
            p_flush   = (ep % 2 == 1) ? 15 : 0;
            p_bad     = (ep % 3 == 2) ? 30 : 5;
            stall_max = (ep % 4 == 3) ? 25 : 3;
            for (int c = 0; c < EP_CYCLES; c++) begin
                run_cycle();
            end
            // Asynchronous reset in whatever state the episode reached.
            req_if.req0_valid = 1'b1;
            req_if.req1_valid = 1'b1;
            reset = 1'b1;
            #1;
            model_reset();
            check_outputs();
            check_val("midrst_ready0", 32'(req_if.req0_ready), 32'd0);
            check_val("midrst_ready1", 32'(req_if.req1_ready), 32'd0);
            @(negedge clk);
            zero_inputs();
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
